// File: rtl/archie_ul_pkg.sv
// Shared types and constants for the SDRAM upload (read-back) path.
package archie_ul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDone
  } ul_state_e;

  localparam logic [2:0]  WB_CTI_CLASSIC = 3'b000;
  localparam logic [15:0] DEAD_PATTERN   = 16'hDEAD;

  // addr[1]=0 selects the low half-word, addr[1]=1 the high half-word.
  function automatic logic [15:0] lane_sel(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/wb_upload_reader.sv
// HPS upload read-back: turns 16-bit ioctl reads into wishbone classic 32-bit SDRAM reads,
// with a one-word cache so the second half-word of a word is served without a bus cycle.
module wb_upload_reader #(
  parameter logic [25:0] BASE_ADDR = 26'h400000,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        upload,
  input  logic [24:0] ioctl_addr,
  input  logic        ioctl_rd,
  output logic [15:0] ioctl_din,
  output logic        ioctl_wait,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [2:0]  wb_cti,
  output logic [25:0] wb_adr,
  input  logic        wb_ack,
  input  logic [31:0] wb_dat_i,
  output logic        busy,
  output logic        error
);
  import archie_ul_pkg::*;

  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  ul_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic        upload_q, upload_d;
  logic [24:1] addr_q, addr_d;
  logic [31:0] cache_q, cache_d;
  logic [22:0] tag_q, tag_d;
  logic        valid_q, valid_d;
  logic [15:0] din_q, din_d;
  logic        wait_q, wait_d;
  logic        cyc_q, cyc_d;
  logic [25:0] adr_q, adr_d;
  logic        busy_q, busy_d;
  logic        error_q, error_d;
  logic        session_start;
  logic        hit;
  logic        unused_addr0;

  assign unused_addr0 = ioctl_addr[0];

  assign session_start = upload & ~upload_q;
  // A request in the same cycle as a session start must not hit on stale data.
  assign hit     = valid_q & ~session_start & (tag_q == ioctl_addr[24:2]);
  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    upload_d = upload;
    addr_d   = addr_q;
    cache_d  = cache_q;
    tag_d    = tag_q;
    valid_d  = valid_q;
    din_d    = din_q;
    wait_d   = wait_q;
    cyc_d    = cyc_q;
    adr_d    = adr_q;
    error_d  = error_q;

    if (session_start) begin
      valid_d = 1'b0;
      error_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (ioctl_rd && upload) begin
          if (hit) begin
            din_d = lane_sel(cache_q, ioctl_addr[1]);
          end else begin
            addr_d  = ioctl_addr[24:1];
            adr_d   = BASE_ADDR + {1'b0, ioctl_addr[24:2], 2'b00};
            cyc_d   = 1'b1;
            wait_d  = 1'b1;
            cnt_d   = '0;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (wb_ack) begin
          cache_d = wb_dat_i;
          tag_d   = addr_q[24:2];
          valid_d = 1'b1;
          din_d   = lane_sel(wb_dat_i, addr_q[1]);
          cyc_d   = 1'b0;
          wait_d  = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_inc == CntW'(TIMEOUT)) begin
          // cnt_inc counts READ cycles including this one, so wb_cyc is high TIMEOUT cycles.
          cyc_d   = 1'b0;
          din_d   = DEAD_PATTERN;
          error_d = 1'b1;
          wait_d  = 1'b0;
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = upload | (state_d != StIdle);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      upload_q <= 1'b0;
      addr_q   <= '0;
      cache_q  <= '0;
      tag_q    <= '0;
      valid_q  <= 1'b0;
      din_q    <= '0;
      wait_q   <= 1'b0;
      cyc_q    <= 1'b0;
      adr_q    <= '0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      upload_q <= upload_d;
      addr_q   <= addr_d;
      cache_q  <= cache_d;
      tag_q    <= tag_d;
      valid_q  <= valid_d;
      din_q    <= din_d;
      wait_q   <= wait_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
      busy_q   <= busy_d;
      error_q  <= error_d;
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign wb_cyc     = cyc_q;
  assign wb_stb     = cyc_q;
  assign wb_we      = 1'b0;
  assign wb_sel     = 4'b1111;
  assign wb_cti     = WB_CTI_CLASSIC;
  assign wb_adr     = adr_q;
  assign busy       = busy_q;
  assign error      = error_q;

endmodule

// File: tb/tb_wb_upload_reader.sv
// Scoreboard bench for wb_upload_reader: stimulus pushes expected responses, a negedge monitor
// pops them when the DUT retires a request (ioctl_wait and wb_cyc both low).
module tb_wb_upload_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        upload = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic        ioctl_rd = 1'b0;
  logic [15:0] ioctl_din, ioctl_din_w;
  logic        ioctl_wait, ioctl_wait_w;
  logic        wb_cyc, wb_stb, wb_we, wb_cyc_w, wb_stb_w, wb_we_w;
  logic [3:0]  wb_sel, wb_sel_w;
  logic [2:0]  wb_cti, wb_cti_w;
  logic [25:0] wb_adr, wb_adr_w;
  logic        wb_ack;
  logic [31:0] wb_dat;
  logic        busy, busy_w, error, error_w;

  logic        model_ack = 1'b0;
  logic        force_ack = 1'b0;
  logic [31:0] model_dat = '0;
  logic        ack_en = 1'b1;
  int          ack_delay = 2;
  int          lat = 0;
  logic [31:0] word0 = 32'h1234ABCD;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] din;
    bit          miss;
    logic [25:0] adr;
    bit          err;
    int          cyc_len;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign wb_ack = model_ack | force_ack;
  assign wb_dat = model_dat;

  wb_upload_reader #(.BASE_ADDR(26'h400000), .TIMEOUT(15)) dut (
    .clk_sys(clk), .reset(reset), .upload(upload), .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_adr(wb_adr), .wb_ack(wb_ack),
    .wb_dat_i(wb_dat), .busy(busy), .error(error)
  );

  // Second instance only to observe address wrap at the top of the 26-bit space.
  wb_upload_reader #(.BASE_ADDR(26'h3FFFFFC), .TIMEOUT(15)) dut_w (
    .clk_sys(clk), .reset(reset), .upload(upload), .ioctl_addr(ioctl_addr), .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din_w), .ioctl_wait(ioctl_wait_w), .wb_cyc(wb_cyc_w), .wb_stb(wb_stb_w),
    .wb_we(wb_we_w), .wb_sel(wb_sel_w), .wb_cti(wb_cti_w), .wb_adr(wb_adr_w), .wb_ack(wb_ack),
    .wb_dat_i(wb_dat), .busy(busy_w), .error(error_w)
  );

  function automatic logic [31:0] mem_word(input logic [25:0] a);
    if (a == 26'h400000) return word0;
    if (a == 26'h400004) return 32'h56789ABC;
    return {6'b0, a};
  endfunction

  // SDRAM model: ack after ack_delay cycles of wb_cyc, one-cycle pulse.
  always @(posedge clk) begin
    if (wb_cyc && wb_stb && !model_ack && ack_en) begin
      if (lat >= ack_delay) begin
        model_ack <= 1'b1;
        model_dat <= mem_word(wb_adr);
        lat       <= 0;
      end else begin
        lat <= lat + 1;
      end
    end else begin
      model_ack <= 1'b0;
      lat       <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  initial begin
    bit          started = 0;
    bit          first_wait = 0;
    bit          saw_cyc = 0;
    logic [25:0] seen_adr = '0;
    int          cyc_n = 0;
    int          age = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        if (!started) begin
          started    = 1;
          first_wait = ioctl_wait;
          saw_cyc    = 0;
          cyc_n      = 0;
          age        = 0;
        end
        if (wb_cyc) begin
          if (!saw_cyc) seen_adr = wb_adr;
          saw_cyc = 1;
          cyc_n++;
        end
        age++;
        if (!ioctl_wait && !wb_cyc) begin
          e = sb.pop_front();
          chk("ioctl_din", {16'h0, ioctl_din}, {16'h0, e.din});
          chk("bus_cycle_used", {31'h0, saw_cyc}, {31'h0, e.miss});
          chk("wait_at_first_cycle", {31'h0, first_wait}, {31'h0, e.miss});
          chk("error", {31'h0, error}, {31'h0, e.err});
          if (e.miss) chk("wb_adr", {6'h0, seen_adr}, {6'h0, e.adr});
          if (e.cyc_len != 0) chk("wb_cyc_len", cyc_n, e.cyc_len);
          started = 0;
        end else if (age > 200) begin
          e = sb.pop_front();
          total++;
          bad++;
          $display("FAIL response_timeout: no retire after %0d cycles, wanted din %h", age, e.din);
          started = 0;
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d responses still pending, wanted 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_rd(input logic [24:0] a, input logic [15:0] din, input bit miss,
                       input logic [25:0] adr, input bit err, input int len);
    exp_t e;
    @(posedge clk); #1;
    ioctl_rd   = 1'b1;
    ioctl_addr = a;
    @(posedge clk); #1;
    ioctl_rd = 1'b0;
    e.din = din; e.miss = miss; e.adr = adr; e.err = err; e.cyc_len = len;
    sb.push_back(e);
    drain();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", {31'h0, wb_cyc}, 32'h0);
    chk("rst_wait", {31'h0, ioctl_wait}, 32'h0);
    chk("rst_din", {16'h0, ioctl_din}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_error", {31'h0, error}, 32'h0);
    chk("rst_adr", {6'h0, wb_adr}, 32'h0);
    reset = 1'b0;
    upload = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("busy_session", {31'h0, busy}, 32'h1);

    do_rd(25'h0, 16'hABCD, 1, 26'h400000, 0, 0);
    do_rd(25'h2, 16'h1234, 0, 26'h0, 0, 0);
    do_rd(25'h6, 16'h5678, 1, 26'h400004, 0, 0);
    chk("wrap_adr", {6'h0, wb_adr_w}, 32'h0);
    chk("wrap_din", {16'h0, ioctl_din_w}, 32'h5678);

    // Reset mid-READ, then a stray ack in IDLE.
    ack_delay = 8;
    @(posedge clk); #1;
    ioctl_rd = 1'b1;
    ioctl_addr = 25'hC;
    @(posedge clk); #1;
    ioctl_rd = 1'b0;
    @(posedge clk); #1;
    chk("midread_cyc", {31'h0, wb_cyc}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstmid_cyc", {31'h0, wb_cyc}, 32'h0);
    chk("rstmid_stb", {31'h0, wb_stb}, 32'h0);
    chk("rstmid_wait", {31'h0, ioctl_wait}, 32'h0);
    chk("rstmid_din", {16'h0, ioctl_din}, 32'h0);
    chk("rstmid_busy", {31'h0, busy}, 32'h0);
    chk("rstmid_adr", {6'h0, wb_adr}, 32'h0);
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(posedge clk); #1;
    chk("late_ack_din", {16'h0, ioctl_din}, 32'h0);
    chk("late_ack_cyc", {31'h0, wb_cyc}, 32'h0);
    ack_delay = 2;

    // Word 4 was cached before reset; it must be fetched again.
    do_rd(25'h4, 16'h9ABC, 1, 26'h400004, 0, 0);

    ack_en = 1'b0;
    do_rd(25'h8, 16'hDEAD, 1, 26'h400008, 1, 15);
    ack_en = 1'b1;
    do_rd(25'h6, 16'h5678, 0, 26'h0, 1, 0);

    upload = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("busy_after_session", {31'h0, busy}, 32'h0);
    chk("error_sticky", {31'h0, error}, 32'h1);
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h10;
    @(posedge clk); #1;
    ioctl_rd = 1'b0;
    chk("no_upload_cyc", {31'h0, wb_cyc}, 32'h0);
    chk("no_upload_wait", {31'h0, ioctl_wait}, 32'h0);
    chk("no_upload_din", {16'h0, ioctl_din}, 32'h5678);

    word0 = 32'h0;
    upload = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("restart_error_clr", {31'h0, error}, 32'h0);
    chk("restart_busy", {31'h0, busy}, 32'h1);
    do_rd(25'h0, 16'h0000, 1, 26'h400000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
